// File: rtl/ehl_ahb_burst_arbiter.sv
// ehl_ahb_burst_arbiter
//   Round-robin, burst-aware AHB arbiter for MNUM masters that share one slave.
//   The grant is held for the whole of a defined-length burst, an INCR burst
//   or a locked sequence. When no other master is requesting, the grant parks
//   on the last owner.
//
// Parameters
//   MNUM         number of masters (2..16)
//
// Ports
//   hclk         clock, rising edge
//   hresetn      asynchronous active-low reset
//   m_htrans     per-master HTRANS, master i at [2i+1:2i]
//   m_hburst     per-master HBURST, master i at [3i+2:3i]
//   m_hmastlock  per-master HMASTLOCK (used only with EHL_AHB_ARB_LOCK_EN)
//   s_hready     HREADY from the shared slave
//   grant        registered one-hot address-phase owner (zero when none)
//   dgrant       registered one-hot data-phase owner
//   m_hready     per-master HREADY
//   busy         arbiter is not in ARB_IDLE
//
// Configuration
//   EHL_AHB_ARB_LOCK_EN  when defined, an owner that holds HMASTLOCK high at a
//                        release point keeps the bus.
module ehl_ahb_burst_arbiter #(
  parameter int MNUM = 4
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic [MNUM*2-1:0] m_htrans,
  input  logic [MNUM*3-1:0] m_hburst,
  input  logic [MNUM-1:0]   m_hmastlock,
  input  logic              s_hready,
  output logic [MNUM-1:0]   grant,
  output logic [MNUM-1:0]   dgrant,
  output logic [MNUM-1:0]   m_hready,
  output logic              busy
);

  localparam int PW = $clog2(MNUM);

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;
  localparam logic [2:0] HB_INCR   = 3'b001;

  typedef enum logic [1:0] {ARB_IDLE, ARB_GNT, ARB_BURST} arb_state_t;

  arb_state_t      state_q, state_n;
  logic [MNUM-1:0] grant_q, grant_n;
  logic [MNUM-1:0] dgrant_q;
  logic [PW-1:0]   ptr_q, ptr_n;      // last (current) owner
  logic [3:0]      cnt_q, cnt_n;
  logic            incr_q, incr_n;

  logic [MNUM-1:0] req;
  logic [1:0]      own_trans;
  logic [2:0]      own_burst;
  logic            accept;
  logic            rel;
  logic            any_v, oth_v;
  logic [PW-1:0]   any_idx, oth_idx;

  // Beats remaining after the NONSEQ beat; INCR is flagged separately.
  function automatic logic [3:0] burst_rem(input logic [2:0] hb);
    case (hb[2:1])
      2'b01:   burst_rem = 4'd3;
      2'b10:   burst_rem = 4'd7;
      2'b11:   burst_rem = 4'd15;
      default: burst_rem = 4'd0;
    endcase
  endfunction

  // Round-robin search starting at the index after p, wrapping to 0.
  function automatic logic [PW:0] rr_pick(input logic [MNUM-1:0] r,
                                          input logic [PW-1:0]   p);
    logic          found;
    logic [PW-1:0] res;
    logic [PW-1:0] ix;
    int            idx;
    found = 1'b0;
    res   = '0;
    for (int k = 1; k <= MNUM; k++) begin
      idx = int'(p) + k;
      if (idx >= MNUM) idx = idx - MNUM;
      ix = PW'(idx);
      if (!found && r[ix]) begin
        found = 1'b1;
        res   = ix;
      end
    end
    rr_pick = {found, res};
  endfunction

  always_comb begin
    req       = '0;
    own_trans = HT_IDLE;
    own_burst = '0;
    for (int i = 0; i < MNUM; i++) begin
      req[i] = (m_htrans[2*i +: 2] == HT_NONSEQ);
      if (ptr_q == PW'(i)) begin
        own_trans = m_htrans[2*i +: 2];
        own_burst = m_hburst[3*i +: 3];
      end
    end
  end

`ifdef EHL_AHB_ARB_LOCK_EN
  logic own_lock;
  assign own_lock = m_hmastlock[ptr_q];
`else
  logic unused_lock;
  assign unused_lock = ^m_hmastlock;
`endif

  assign accept = s_hready & (|grant_q) & own_trans[1];

  always_comb begin
    state_n = state_q;
    grant_n = grant_q;
    ptr_n   = ptr_q;
    cnt_n   = cnt_q;
    incr_n  = incr_q;
    rel     = 1'b0;
    {any_v, any_idx} = rr_pick(req, ptr_q);
    {oth_v, oth_idx} = rr_pick(req & ~grant_q, ptr_q);

    case (state_q)
      ARB_IDLE: begin
        if (any_v) begin
          grant_n = MNUM'(1) << any_idx;
          ptr_n   = any_idx;
          state_n = ARB_GNT;
        end
      end
      ARB_GNT: begin
        if (accept && own_trans == HT_NONSEQ) begin
          cnt_n  = burst_rem(own_burst);
          incr_n = (own_burst == HB_INCR);
          if (burst_rem(own_burst) == 4'd0 && own_burst != HB_INCR) rel = 1'b1;
          else                                                       state_n = ARB_BURST;
        end else if (own_trans == HT_IDLE && oth_v) begin
          // Parked owner is not using the bus: hand it over.
          grant_n = MNUM'(1) << oth_idx;
          ptr_n   = oth_idx;
        end
      end
      ARB_BURST: begin
        if (accept && own_trans == HT_SEQ) begin
          if (!incr_q) begin
            if (cnt_q <= 4'd1) begin
              rel   = 1'b1;
              cnt_n = 4'd0;
            end else begin
              cnt_n = cnt_q - 4'd1;
            end
          end
        end else if (accept && own_trans == HT_NONSEQ) begin
          // Early termination: a fresh burst from the same owner.
          cnt_n  = burst_rem(own_burst);
          incr_n = (own_burst == HB_INCR);
          if (burst_rem(own_burst) == 4'd0 && own_burst != HB_INCR) rel = 1'b1;
        end else if (incr_q && own_trans == HT_IDLE && s_hready) begin
          rel = 1'b1;
        end
      end
      default: state_n = ARB_IDLE;
    endcase

    if (rel) begin
      state_n = ARB_GNT;
`ifdef EHL_AHB_ARB_LOCK_EN
      if (oth_v && !own_lock) begin
`else
      if (oth_v) begin
`endif
        grant_n = MNUM'(1) << oth_idx;
        ptr_n   = oth_idx;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      dgrant_q <= '0;
      ptr_q    <= PW'(MNUM - 1);   // master 0 searched first
      cnt_q    <= 4'd0;
      incr_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      grant_q <= grant_n;
      ptr_q   <= ptr_n;
      cnt_q   <= cnt_n;
      incr_q  <= incr_n;
      if (s_hready) dgrant_q <= accept ? grant_q : '0;
    end
  end

  always_comb begin
    for (int i = 0; i < MNUM; i++) begin
      if (dgrant_q[i] || grant_q[i]) m_hready[i] = s_hready;
      else                           m_hready[i] = ~req[i];
    end
  end

  assign grant  = grant_q;
  assign dgrant = dgrant_q;
  assign busy   = (state_q != ARB_IDLE);

endmodule

// File: doc/ehl_ahb_burst_arbiter.md
EHL_AHB_BURST_ARBITER -- requirements
Module: ehl_ahb_burst_arbiter

Interface
REQ-001 SHALL have parameter: MNUM, 4, number of AHB masters (2..16).
REQ-002 SHALL have port: hclk  input  1  single clock, rising edge.
REQ-003 SHALL have port: hresetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: m_htrans  input  MNUM*2  per-master HTRANS, master i at [2i+1:2i].
REQ-005 SHALL have port: m_hburst  input  MNUM*3  per-master HBURST, master i at [3i+2:3i].
REQ-006 SHALL have port: m_hmastlock  input  MNUM  per-master HMASTLOCK.
REQ-007 SHALL have port: s_hready  input  1  HREADY from the shared slave.
REQ-008 SHALL have port: grant  output  MNUM  registered one-hot address-phase owner, all-zero when none.
REQ-009 SHALL have port: dgrant  output  MNUM  registered one-hot data-phase owner.
REQ-010 SHALL have port: m_hready  output  MNUM  per-master HREADY.
REQ-011 SHALL have port: busy  output  1  high when state is not ARB_IDLE.

Function
REQ-012 SHALL treat req[i] = (m_htrans[i] == NONSEQ); accept = s_hready & owner htrans in {NONSEQ, SEQ}.
REQ-013 SHALL use round-robin: search starts at the index after the last owner, wrapping MNUM-1 -> 0.
REQ-014 SHALL implement states ARB_IDLE, ARB_GNT, ARB_BURST; grant changes only on a clock edge.
REQ-015 ARB_IDLE: grant = 0; any req -> grant RR winner next cycle, go ARB_GNT (1-cycle grant latency).
REQ-016 ARB_GNT: owner NONSEQ accepted -> load beat counter with burst length-1 (SINGLE 0, x4 3, x8 7, x16 15, INCR unbounded flag).
REQ-017 ARB_GNT: loaded count 0 and not INCR -> release point this cycle; otherwise go ARB_BURST.
REQ-018 ARB_BURST: owner SEQ accepted -> decrement; acceptance at count 1 is the release point (last beat); BUSY or s_hready low holds counter.
REQ-019 ARB_BURST INCR: owner IDLE with s_hready high is the release point.
REQ-020 ARB_BURST: owner NONSEQ accepted = early termination; reload counter from its hburst, stay owner.
REQ-021 Release point: winner among req excluding owner -> grant winner, ARB_GNT; no other req -> grant parks on owner, ARB_GNT.
REQ-022 ARB_GNT with owner htrans IDLE and another req present -> regrant to RR winner next cycle.
REQ-023 dgrant SHALL load grant on each accept and clear to 0 on s_hready high without accept; hold when s_hready low.
REQ-024 m_hready[i] SHALL be s_hready if dgrant[i] or grant[i]; else 0 if req[i]; else 1.
REQ-025 Simultaneous requests in ARB_IDLE with reset pointer SHALL grant lowest index.
REQ-026 Counter SHALL be 4 bits, never wrap below 0.

Reset
REQ-027 hresetn low SHALL force at once: state ARB_IDLE, grant 0, dgrant 0, counter 0, RR pointer so master 0 has top priority, busy 0.
REQ-028 Reset mid-burst SHALL abandon the burst; first post-reset grant follows REQ-015.

Configuration
REQ-029 Macro EHL_AHB_ARB_LOCK_EN defined: m_hmastlock[owner] high at a release point suppresses release (owner retained, ARB_GNT).
REQ-030 Macro EHL_AHB_ARB_LOCK_EN undefined: m_hmastlock ignored, no lock logic synthesized.

Verification
REQ-031 Reset, MNUM=4, m0 and m2 NONSEQ SINGLE same cycle -> grant=0001 next cycle, m_hready=1010 during request cycle, then grant=0100 after m0 accept.
REQ-032 m1 INCR4 with s_hready low for 2 cycles on beat 2, m3 requesting -> grant holds 0010 for 4 accepted beats, 0100-free switch to 1000 after beat 4.
REQ-033 m0 INCR 6 beats then IDLE, m1 requesting -> grant switches to 0010 the cycle after IDLE with s_hready high.
REQ-034 m2 WRAP8 terminated by NONSEQ SINGLE at beat 3 -> counter reloads 0, grant releases after that single beat.
REQ-035 EHL_AHB_ARB_LOCK_EN defined, m0 hmastlock=1 two SINGLEs, m1 requesting -> m1 granted only after m0 lock drops; undefined -> m1 granted after first single.
REQ-036 hresetn pulsed low mid-INCR16 -> grant, dgrant, busy 0 immediately; new request granted one cycle after release.
